// File: rtl/pad_trigger_arbiter.sv
// pad_trigger_arbiter
// Captures rising edges on N_IN pad-trigger lines into a pending register and
// hands them out one channel index at a time over a valid/ready slot.
// Arbitration is fixed priority (highest index) or round-robin, chosen per
// selection by rr_en. Hits lost to a re-trigger of a still-pending channel are
// counted in a saturating counter. All outputs come straight from registers.
module pad_trigger_arbiter #(
  parameter int N_IN   = 8,
  parameter int DROP_W = 8,
  localparam int IDX_W = $clog2(N_IN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_IN-1:0]   trig_in,
  input  logic              rr_en,
  output logic              out_valid,
  output logic [IDX_W-1:0]  out_idx,
  input  logic              out_ready,
  output logic [N_IN-1:0]   pending,
  output logic [DROP_W-1:0] drop_cnt
);

  // Up to 32 drops can land in one cycle, so 6 bits hold the per-cycle count.
  localparam int CNT_W = 6;
  localparam int SUM_W = DROP_W + CNT_W;
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

  logic [N_IN-1:0]   trig_prev_r;
  logic [IDX_W-1:0]  ptr_r;

  logic [N_IN-1:0]   rise_s;
  logic              free_s;
  logic              load_s;
  logic [IDX_W-1:0]  fix_idx_s;
  logic [IDX_W-1:0]  rr_idx_s;
  logic [IDX_W-1:0]  win_s;
  logic [N_IN-1:0]   clear_s;
  logic [N_IN-1:0]   drop_bits_s;
  logic [CNT_W-1:0]  drop_num_s;
  logic [SUM_W-1:0]  drop_sum_s;
  logic [N_IN-1:0]   pending_next_s;
  logic [DROP_W-1:0] drop_next_s;

  // Number of set bits in a drop vector.
  function automatic logic [CNT_W-1:0] popcount(input logic [N_IN-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < N_IN; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

  // Edge detect and slot availability.
  always_comb begin
    rise_s = trig_in & ~trig_prev_r;
    free_s = !out_valid || out_ready;
    load_s = free_s && (pending != '0);
  end

  // Fixed-priority winner: scanning upward, the last set bit seen is the highest.
  always_comb begin
    fix_idx_s = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (pending[i]) begin
        fix_idx_s = IDX_W'(i);
      end else begin
        fix_idx_s = fix_idx_s;
      end
    end
  end

  // Round-robin winner: scan offsets from farthest to nearest after ptr, so the
  // nearest set channel after ptr (with wrap) is what remains.
  always_comb begin
    rr_idx_s = '0;
    for (int k = N_IN; k >= 1; k--) begin
      if (pending[(int'(ptr_r) + k) % N_IN]) begin
        rr_idx_s = IDX_W'((int'(ptr_r) + k) % N_IN);
      end else begin
        rr_idx_s = rr_idx_s;
      end
    end
  end

  // Pick the winner, clear its pending bit on load, and account for drops.
  always_comb begin
    win_s = rr_en ? rr_idx_s : fix_idx_s;
    for (int i = 0; i < N_IN; i++) begin
      clear_s[i] = load_s && (win_s == IDX_W'(i));
    end
    // A re-trigger of the channel being loaded this cycle is a fresh hit.
    drop_bits_s    = rise_s & pending & ~clear_s;
    drop_num_s     = popcount(drop_bits_s);
    drop_sum_s     = SUM_W'(drop_cnt) + SUM_W'(drop_num_s);
    pending_next_s = (pending & ~clear_s) | rise_s;
    if (drop_sum_s > SUM_W'(DROP_MAX)) begin
      drop_next_s = DROP_MAX;
    end else begin
      drop_next_s = drop_sum_s[DROP_W-1:0];
    end
  end

  // State and output registers; reset clears everything, ptr parks at N_IN-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trig_prev_r <= '0;
      pending     <= '0;
      out_valid   <= 1'b0;
      out_idx     <= '0;
      drop_cnt    <= '0;
      ptr_r       <= IDX_W'(N_IN - 1);
    end else begin
      trig_prev_r <= trig_in;
      pending     <= pending_next_s;
      drop_cnt    <= drop_next_s;
      if (load_s) begin
        out_valid <= 1'b1;
        out_idx   <= win_s;
        ptr_r     <= win_s;
      end else if (free_s) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end
    end
  end

endmodule

// File: tb/tb_pad_trigger_arbiter.sv
// Self-checking bench for pad_trigger_arbiter: a vector table for the basic
// grant sequences, hand-written multi-cycle sequences, and a randomized run,
// with an 8-channel reference model compared every cycle.
module tb_pad_trigger_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  trig8;
  logic        rr8;
  logic        rdy8;
  logic        out_valid8;
  logic [2:0]  out_idx8;
  logic [7:0]  pend8;
  logic [7:0]  drop8;

  logic [31:0] trig32;
  logic        rr32;
  logic        rdy32;
  logic        out_valid32;
  logic [4:0]  out_idx32;
  logic [31:0] pend32;
  logic [7:0]  drop32;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state (8 channels).
  logic [7:0] m_prev;
  logic [7:0] m_pend;
  bit         m_valid;
  int         m_idx;
  int         m_ptr;
  int         m_drop;

  always #5 clk = ~clk;

  pad_trigger_arbiter #(.N_IN(8), .DROP_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .trig_in(trig8), .rr_en(rr8),
    .out_valid(out_valid8), .out_idx(out_idx8), .out_ready(rdy8),
    .pending(pend8), .drop_cnt(drop8)
  );

  pad_trigger_arbiter #(.N_IN(32), .DROP_W(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .trig_in(trig32), .rr_en(rr32),
    .out_valid(out_valid32), .out_idx(out_idx32), .out_ready(rdy32),
    .pending(pend32), .drop_cnt(drop32)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Winner chosen from a pending set by the arbitration rules.
  function automatic int pick(input logic [7:0] p, input int ptr, input bit rr);
    if (!rr) begin
      for (int i = 7; i >= 0; i--) if (p[i]) return i;
    end else begin
      for (int k = 1; k <= 8; k++) if (p[(ptr + k) % 8]) return (ptr + k) % 8;
    end
    return -1;
  endfunction

  // One clock edge of the model, using the inputs presented at that edge.
  task automatic model_step();
    logic [7:0] rise;
    int loaded;
    if (!rst_n) begin
      m_prev = 8'h00; m_pend = 8'h00; m_valid = 1'b0;
      m_idx = 0; m_ptr = 7; m_drop = 0;
    end else begin
      rise = trig8 & ~m_prev;
      loaded = -1;
      if (!m_valid || rdy8) begin
        if (m_pend != 8'h00) begin
          loaded = pick(m_pend, m_ptr, rr8);
          m_valid = 1'b1;
          m_idx = loaded;
          m_ptr = loaded;
        end else begin
          m_valid = 1'b0;
        end
      end
      for (int i = 0; i < 8; i++) begin
        if (rise[i] && m_pend[i] && i != loaded && m_drop < 255) m_drop = m_drop + 1;
      end
      if (loaded >= 0) m_pend[loaded] = 1'b0;
      m_pend = m_pend | rise;
      m_prev = trig8;
    end
  endtask

  // Advance one cycle, step the model, and compare the 8-channel DUT to it.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model out_valid", 32'(out_valid8), 32'(m_valid));
    check("model out_idx", 32'(out_idx8), 32'(m_idx));
    check("model pending", 32'(pend8), 32'(m_pend));
    check("model drop_cnt", 32'(drop8), 32'(m_drop));
  endtask

  task automatic exp8(input string name, input logic v, input logic [2:0] idx, input logic [7:0] p);
    check({name, " valid"}, 32'(out_valid8), 32'(v));
    check({name, " idx"}, 32'(out_idx8), 32'(idx));
    check({name, " pending"}, 32'(pend8), 32'(p));
  endtask

  typedef struct {
    logic       rst;
    logic [7:0] trig;
    logic       rr;
    logic       rdy;
    logic       v;
    logic [2:0] idx;
    logic [7:0] pend;
  } vec_t;

  vec_t tbl[28];

  initial begin
    // rst, trig, rr, rdy | expected valid, idx, pending after the edge
    tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00};
    tbl[2]  = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 3'd0, 8'h04};
    tbl[3]  = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 3'd2, 8'h00};
    tbl[4]  = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 3'd2, 8'h00};
    tbl[5]  = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 3'd2, 8'h00};
    tbl[6]  = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 3'd2, 8'h00};
    tbl[7]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 3'd2, 8'h00};
    tbl[8]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 3'd2, 8'hA5};
    tbl[9]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 3'd7, 8'h25};
    tbl[10] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 3'd5, 8'h05};
    tbl[11] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 3'd2, 8'h01};
    tbl[12] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 8'h00};
    tbl[13] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00};
    tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00};
    tbl[15] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 3'd0, 8'hA5};
    tbl[16] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 3'd0, 8'hA4};
    tbl[17] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 3'd2, 8'hA0};
    tbl[18] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 3'd5, 8'h80};
    tbl[19] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 3'd7, 8'h00};
    tbl[20] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 3'd7, 8'h00};
    tbl[21] = '{1'b1, 8'h20, 1'b1, 1'b1, 1'b0, 3'd7, 8'h20};
    tbl[22] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 3'd5, 8'h00};
    tbl[23] = '{1'b1, 8'h25, 1'b1, 1'b1, 1'b0, 3'd5, 8'h25};
    tbl[24] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 3'd0, 8'h24};
    tbl[25] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 3'd2, 8'h20};
    tbl[26] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 3'd5, 8'h00};
    tbl[27] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 3'd5, 8'h00};

    rst_n = 1'b0; trig8 = 8'h00; rr8 = 1'b0; rdy8 = 1'b1;
    trig32 = 32'h0; rr32 = 1'b0; rdy32 = 1'b1;

    // Table: reset, single hit, fixed priority, round-robin.
    for (int k = 0; k < 28; k++) begin
      rst_n = tbl[k].rst; trig8 = tbl[k].trig; rr8 = tbl[k].rr; rdy8 = tbl[k].rdy;
      tick();
      exp8($sformatf("vec%0d", k), tbl[k].v, tbl[k].idx, tbl[k].pend);
      if (k == 1) check("reset drop_cnt", 32'(drop8), 32'h0);
    end
    check("single hit drop_cnt", 32'(drop8), 32'h0);

    // Backpressure: hold ch3 while ch6 hits.
    rr8 = 1'b0; rdy8 = 1'b0; trig8 = 8'h08;
    tick();
    tick();
    exp8("bp grant3", 1'b1, 3'd3, 8'h00);
    trig8 = 8'h48;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp8($sformatf("bp hold%0d", k), 1'b1, 3'd3, 8'h40);
    end
    rdy8 = 1'b1;
    tick();
    exp8("bp grant6", 1'b1, 3'd6, 8'h00);
    tick();
    exp8("bp idle", 1'b0, 3'd6, 8'h00);

    // Drops: slot holds ch1 under backpressure, ch1 re-trigger, ch4 toggled.
    rdy8 = 1'b0; trig8 = 8'h02;
    tick();
    tick();
    exp8("drop slot1", 1'b1, 3'd1, 8'h00);
    trig8 = 8'h00;
    tick();
    trig8 = 8'h02;
    tick();
    exp8("retrig held ch", 1'b1, 3'd1, 8'h02);
    check("retrig no drop", 32'(drop8), 32'h0);
    for (int k = 0; k < 300; k++) begin
      trig8 = 8'h12;
      tick();
      trig8 = 8'h02;
      tick();
    end
    exp8("sat", 1'b1, 3'd1, 8'h12);
    check("sat drop_cnt", 32'(drop8), 32'd255);

    // Reset while a grant is held.
    rst_n = 1'b0;
    tick();
    exp8("midrst", 1'b0, 3'd0, 8'h00);
    check("midrst drop_cnt", 32'(drop8), 32'h0);
    rst_n = 1'b1; trig8 = 8'h00; rdy8 = 1'b1;
    tick();
    exp8("midrst after", 1'b0, 3'd0, 8'h00);

    // 32-channel instance, fixed priority on channels 31 and 0.
    trig32 = 32'h8000_0001;
    tick();
    check("n32 pend", pend32, 32'h8000_0001);
    check("n32 valid0", 32'(out_valid32), 32'h0);
    tick();
    check("n32 valid1", 32'(out_valid32), 32'h1);
    check("n32 idx31", 32'(out_idx32), 32'd31);
    check("n32 pend1", pend32, 32'h0000_0001);
    tick();
    check("n32 valid2", 32'(out_valid32), 32'h1);
    check("n32 idx0", 32'(out_idx32), 32'd0);
    check("n32 pend2", pend32, 32'h0);
    tick();
    check("n32 idle", 32'(out_valid32), 32'h0);
    check("n32 drop", 32'(drop32), 32'h0);

    // Randomized run against the model.
    for (int k = 0; k < 3000; k++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      trig8 = trig8 ^ 8'($urandom & $urandom);
      if ($urandom_range(0, 9) == 0) rr8 = 1'($urandom_range(0, 1));
      rdy8 = ($urandom_range(0, 9) < 6);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pad_trigger_arbiter.md
Name: pad_trigger_arbiter

Overview:
Parametrised successor to the combinational 8-to-3 priority encoder. Captures rising edges on N pad-trigger lines into a pending register and serialises them, one channel index per transfer, to the voice/sample-playback stage over a valid/ready handshake. Arbitration is run-time selectable: fixed priority (highest index wins) or round-robin. Dropped re-triggers are counted.

Parameters:
N_IN, 8, number of trigger channels; legal range 2..32.
IDX_W, $clog2(N_IN), width of the channel index; derived localparam, not overridable.
DROP_W, 8, width of the saturating drop counter.

Ports:
clk  input  1  system clock, all logic on the rising edge
rst_n  input  1  synchronous reset, active-low
trig_in  input  N_IN  synchronous pad trigger levels; a 0->1 transition is one hit
rr_en  input  1  0 = fixed priority (highest index wins), 1 = round-robin
out_valid  output  1  out_idx holds a granted channel
out_idx  output  IDX_W  granted channel index
out_ready  input  1  consumer accepts out_idx when out_valid & out_ready
pending  output  N_IN  hits captured but not yet loaded into the output slot
drop_cnt  output  DROP_W  saturating count of lost hits

Behaviour:
- Reset (rst_n=0 at a clock edge): trig_prev, pending, out_valid, out_idx and drop_cnt all clear to 0. The round-robin pointer clears to N_IN-1, so the first RR search starts at channel 0. Reset overrides all other activity, including a transfer in progress.
- Edge detect: rise = trig_in & ~trig_prev; trig_prev <= trig_in every cycle. A held level produces exactly one hit.
- Output slot: a single register (out_valid, out_idx). It may load when free: free = !out_valid | out_ready.
- Selection when free:
  - If pending != 0, choose winner w from the current pending register. Then out_valid <= 1, out_idx <= w, and pending[w] clears.
  - If pending == 0, out_valid <= 0 (out_idx holds its old value).
  - A hit is cleared from pending when it is loaded into the slot, not when it is accepted.
- Fixed mode (rr_en=0): w is the highest set index, the same semantics as the 8-to-3 encoder.
- RR mode (rr_en=1): w is the first set bit searching ptr+1, ptr+2, … with wrap modulo N_IN. On each load, ptr <= w. The pointer is also updated on loads made in fixed mode.
- rr_en is sampled at the selection edge. A change affects the next selection only and never alters a held out_idx.
- Hold rule: while out_valid=1 and out_ready=0, out_idx and out_valid are stable.
- Latency: a 0->1 on trig_in[i] sampled at edge k sets pending[i] at edge k. If the slot is free at edge k+1 and i wins, out_valid=1 and out_idx=i after edge k+1. Minimum latency is 2 cycles.
- Throughput: one grant per cycle while out_ready=1 and pending is nonzero.
- Pending update priority: pending_next = (pending & ~clear_w) | rise.
  - A rise on channel w in the same cycle w is loaded leaves pending[w]=1. This is a new hit, not a drop.
- Drop: a rise on channel i while pending[i]=1 and i is not being loaded in that cycle loses the hit. drop_cnt increments by 1 per dropped channel-bit, so multiple drops in one cycle add their count. drop_cnt saturates at 2^DROP_W-1.
- A rise on a channel currently held in the output slot is not a drop; it sets pending.
- No combinational path from out_ready or trig_in to any output. All outputs are registers.

Test Plan:
- Reset / single hit: rst_n low 2 cycles -> all outputs 0. Then trig_in=8'h04 held 5 cycles, out_ready=1 -> out_valid=1, out_idx=2 exactly one cycle, 2 cycles after the edge. No further grants; drop_cnt=0.
- Fixed priority: trig_in 0->8'hA5 in one cycle, rr_en=0, out_ready=1 -> out_idx sequence 7,5,2,0 on consecutive cycles. Then out_valid=0 and pending=0.
- Round-robin: after reset, rr_en=1; trig_in 0->8'hA5 -> 0,2,5,7. Repeat with ptr=5 and hits 8'h25 -> 0,2,5.
- Backpressure: grant out_idx=3 with out_ready=0 for 4 cycles while channel 6 hits -> out_idx stays 3, pending=8'h40. Release out_ready -> 3 accepted, 6 follows next cycle.
- Drops / saturation: with out_ready=0 and a slot holding ch1, toggle trig_in[4] 0->1->0 300 times -> pending[4]=1, drop_cnt=255 (DROP_W=8). Re-trigger ch1 -> pending[1]=1, no drop.
- Mid-operation reset / N_IN=32: rst_n low while out_valid=1 -> next cycle all clear, no stale grant. Repeat the fixed-priority case with N_IN=32 and hits on 31 and 0 -> 31, then 0.
